// File: rtl/serial_paralelo_sync.sv
// Receive-side serial-to-parallel converter with COM-symbol byte alignment.
// Locks byte boundaries to COM_SYMBOL, then emits one registered byte per 8 bit-clocks.
module serial_paralelo_sync #(
  parameter logic [7:0]  COM_SYMBOL   = 8'hBC,
  parameter int unsigned ACTIVE_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  typedef enum logic [1:0] {StSearch, StAlign, StActive} state_e;

  localparam logic [3:0] ComTarget = 4'(ACTIVE_COUNT);

  state_e      state_q;
  logic [7:0]  sr_q;
  logic [2:0]  bit_cnt_q;
  logic [3:0]  com_cnt_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        stb_q;
  logic        active_q;

  logic [7:0]  cand;
  logic        byte_done;
  logic        is_com;
  logic [3:0]  com_cnt_inc;

  // Candidate byte includes the bit being sampled on this edge.
  always_comb begin
    cand        = {sr_q[6:0], data_in};
    byte_done   = (bit_cnt_q == 3'd7);
    is_com      = (cand == COM_SYMBOL);
    com_cnt_inc = com_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StSearch;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      stb_q     <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sr_q  <= cand;
      stb_q <= 1'b0;
      unique case (state_q)
        StSearch: begin
          // Bit-granular hunt: any edge may start a byte boundary.
          if (is_com) begin
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd1;
            if (ComTarget == 4'd1) begin
              state_q  <= StActive;
              active_q <= 1'b1;
            end else begin
              state_q <= StAlign;
            end
          end
        end
        StAlign: begin
          bit_cnt_q <= byte_done ? 3'd0 : bit_cnt_q + 3'd1;
          if (byte_done) begin
            if (is_com) begin
              if (com_cnt_q < ComTarget) com_cnt_q <= com_cnt_inc;
              if (com_cnt_inc == ComTarget) begin
                state_q  <= StActive;
                active_q <= 1'b1;
              end
            end else begin
              com_cnt_q <= 4'd0;
              state_q   <= StSearch;
            end
          end
        end
        StActive: begin
          bit_cnt_q <= byte_done ? 3'd0 : bit_cnt_q + 3'd1;
          if (byte_done) begin
            data_q  <= cand;
            valid_q <= !is_com;
            stb_q   <= 1'b1;
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule

// File: doc/serial_paralelo_sync.md
Name: serial_paralelo_sync

Overview:
- Receive-side serial-to-parallel converter with COM-symbol byte alignment for the PCIe physical-layer lane.
- Sits directly upstream of the 1:2 byte demux. Its data_out and valid_out drive the demux's in[7:0] and valid.
- Searches the incoming bit stream for the COM symbol (K28.5 byte 8'hBC) and locks byte boundaries to it.
- Declares the lane active after a run of consecutive aligned COMs, then emits one byte per 8 bit-clocks.

Parameters:
- COM_SYMBOL, 8'hBC, byte value used for alignment and idle fill.
- ACTIVE_COUNT, 4, consecutive aligned COMs required to enter ACTIVE. Legal range 1..15.

Ports:
- clk  input  1  bit-rate clock; every register updates on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- data_in  input  1  serial bit, MSB first, sampled on rising clk.
- data_out  output  8  last completed byte while ACTIVE; otherwise 8'h00.
- valid_out  output  1  high when data_out holds a non-COM byte while ACTIVE.
- byte_stb  output  1  one-cycle pulse, in ACTIVE only, on the edge data_out updates.
- active  output  1  high while the state machine is in ACTIVE.

Behaviour:
- Reset (async, active-high): shift register=0, bit_cnt=0, com_cnt=0, state=SEARCH, data_out=8'h00, valid_out=0, byte_stb=0, active=0. Reset asserted mid-operation drops the lane to SEARCH at once.
- Shifting: every edge, sr <= {sr[6:0], data_in}. The candidate byte is cand = {sr[6:0], data_in}, i.e. the 8 most recent bits including the current one.
- bit_cnt (3 bits) counts bits already received of the current byte.
  - At each edge outside SEARCH: if bit_cnt==7 the byte is complete (cand is the byte) and bit_cnt <= 0; else bit_cnt <= bit_cnt+1.
- SEARCH:
  - Checks every edge, with no byte-boundary assumption: if cand==COM_SYMBOL, then bit_cnt <= 0 and com_cnt <= 1.
  - If ACTIVE_COUNT==1 go straight to ACTIVE; else go to ALIGN.
- ALIGN (byte-complete edges only):
  - cand==COM_SYMBOL: com_cnt <= com_cnt+1. If com_cnt+1 == ACTIVE_COUNT, go to ACTIVE.
  - cand!=COM_SYMBOL: com_cnt <= 0 and return to SEARCH. A fresh bit-level search starts on the next edge.
- ACTIVE: active=1 registered on the same edge as the state change. The first data byte completes 8 edges after entry. On each byte-complete edge:
  - data_out <= cand.
  - valid_out <= (cand != COM_SYMBOL).
  - byte_stb <= 1 for exactly that cycle.
  - data_out and valid_out hold between strobes.
- ACTIVE persists until reset; there is no loss-of-lock exit.
- Outputs are registered. Latency is 0 cycles from the edge sampling the byte's last bit to data_out and byte_stb changing on that same edge. byte_stb period is exactly 8 clk.
- Outside ACTIVE: data_out=8'h00, valid_out=0, byte_stb=0.
- A COM pattern that straddles bytes is ignored in ALIGN and ACTIVE, because only boundary-aligned candidates are compared.
- com_cnt saturates at ACTIVE_COUNT.

Test Plan:
- Reset then 4×8'hBC aligned, then 8'hFF, 8'hDD -> active rises on the edge of the 4th BC's last bit. data_out=8'hFF with valid_out=1 and byte_stb pulse 8 clk later, then 8'hDD 8 clk after that.
- 3 idle '0' bits, then 4×BC, 8'hEE -> lock at the bit offset; active after the 4th BC; data_out=8'hEE, valid_out=1.
- 2×BC, 8'h55, then 4×BC, 8'hAA -> first run returns to SEARCH with active=0; second run locks; data_out=8'hAA.
- ACTIVE stream 8'hCC, 8'hBC, 8'h99 -> strobes every 8 clk; valid_out = 1, 0, 1; data_out = 8'hCC, 8'hBC, 8'h99.
- Assert reset for 3 clk mid-byte while ACTIVE -> all outputs 0 immediately (asynchronous); 4 new BCs are needed to reach active again.
- ACTIVE_COUNT=1: single BC then 8'h77 -> active after the one BC; data_out=8'h77 8 clk later.
